// File: rtl/pipelined_right_barrel_shifter_pkg.sv
// Shared helpers for the pipelined right barrel shifter: derived shift width and width legality.
// Optional arithmetic fill is selected per build with RIGHT_SHIFT_ARITH_EN.
package pipelined_right_barrel_shifter_pkg;

    function automatic int calc_sw(input int n);
        return $clog2(n);
    endfunction

    function automatic bit width_ok(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered stage of the log shifter: conditionally shifts right by 2^K, loads only on advance.
// With RIGHT_SHIFT_ARITH_EN the operand sign rides along as a sideband and fills vacated MSBs.
module barrel_shift_stage
    import pipelined_right_barrel_shifter_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = 3,
    parameter int K  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shamt,
`ifdef RIGHT_SHIFT_ARITH_EN
    input  logic          in_sign,
    output logic          out_sign,
`endif
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic [SW-1:0] out_shamt
);

    localparam int DIST = 1 << K;

    logic [N-1:0] shifted;

    always_comb begin
        shifted = in_data;
        if (in_shamt[K]) begin
`ifdef RIGHT_SHIFT_ARITH_EN
            // Inverting around a logical shift fills with ones for negative operands.
            shifted = in_sign ? ~((~in_data) >> DIST) : (in_data >> DIST);
`else
            shifted = in_data >> DIST;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_shamt <= in_shamt;
        end
    end

`ifdef RIGHT_SHIFT_ARITH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sign <= 1'b0;
        end else if (advance) begin
            out_sign <= in_sign;
        end
    end
`endif

endmodule

// File: rtl/pipelined_right_barrel_shifter.sv
// Variable right shifter as SW registered log stages with valid/ready; one word per cycle, SW-cycle latency.
// A stalled output freezes every stage (up_ready = !down_valid || down_ready); RIGHT_SHIFT_ARITH_EN selects sign fill.
module pipelined_right_barrel_shifter
    import pipelined_right_barrel_shifter_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = calc_sw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    generate
        if (!width_ok(N)) begin : g_bad_width
            $error("pipelined_right_barrel_shifter: N must be a power of two and at least 2");
        end
    endgenerate

    // Index 0 is the upstream port; index k+1 is the register output of stage k.
    logic          valid_pipe [0:SW];
    logic [N-1:0]  data_pipe  [0:SW];
    logic [SW-1:0] shamt_pipe [0:SW];
`ifdef RIGHT_SHIFT_ARITH_EN
    logic          sign_pipe  [0:SW];
`endif

    logic advance;

    assign advance  = !down_valid || down_ready;
    assign up_ready = advance;

    assign valid_pipe[0] = up_valid;
    assign data_pipe[0]  = up_data;
    assign shamt_pipe[0] = up_shamt;
`ifdef RIGHT_SHIFT_ARITH_EN
    assign sign_pipe[0]  = up_data[N-1];
`endif

    generate
        for (genvar k = 0; k < SW; k++) begin : g_stage
            barrel_shift_stage #(
                .N  (N),
                .SW (SW),
                .K  (k)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .advance   (advance),
                .in_valid  (valid_pipe[k]),
                .in_data   (data_pipe[k]),
                .in_shamt  (shamt_pipe[k]),
`ifdef RIGHT_SHIFT_ARITH_EN
                .in_sign   (sign_pipe[k]),
                .out_sign  (sign_pipe[k+1]),
`endif
                .out_valid (valid_pipe[k+1]),
                .out_data  (data_pipe[k+1]),
                .out_shamt (shamt_pipe[k+1])
            );
        end
    endgenerate

    assign down_valid = valid_pipe[SW];
    assign down_data  = data_pipe[SW];

endmodule

// File: tb/tb_pipelined_right_barrel_shifter.sv
// Directed self-checking bench for pipelined_right_barrel_shifter (N = 8); honours RIGHT_SHIFT_ARITH_EN.
module tb_pipelined_right_barrel_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_valid = 1'b0;
    logic       up_ready;
    logic [7:0] up_data = '0;
    logic [2:0] up_shamt = '0;
    logic       down_valid;
    logic       down_ready = 1'b0;
    logic [7:0] down_data;

    int vecs = 0;
    int errs = 0;
    logic [7:0] exp_q [$];

    pipelined_right_barrel_shifter #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_shamt   (up_shamt),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] s);
`ifdef RIGHT_SHIFT_ARITH_EN
        logic signed [7:0] sa;
        sa = $signed(a);
        return sa >>> s;
`else
        return a >> s;
`endif
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vecs++; if (down_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b req=0", down_valid); end
        vecs++; if (down_data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h req=00", down_data); end
        down_ready = 1'b1;
        #1;
        vecs++; if (up_ready !== 1'b1) begin errs++; $display("FAIL reset_up_ready got=%b req=1", up_ready); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] req;
`ifdef RIGHT_SHIFT_ARITH_EN
        req = 8'hF6;
`else
        req = 8'h16;
`endif
        @(negedge clk);
        down_ready = 1'b1;
        up_valid = 1'b1; up_data = 8'hB4; up_shamt = 3'd3;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            up_valid = 1'b0;
            #1;
            if (c == 3) begin
                vecs++; if (down_valid !== 1'b1) begin errs++; $display("FAIL basic_valid c=%0d got=%b req=1", c, down_valid); end
                vecs++; if (down_data !== req) begin errs++; $display("FAIL basic_data got=%h req=%h", down_data, req); end
            end else begin
                vecs++; if (down_valid !== 1'b0) begin errs++; $display("FAIL basic_valid c=%0d got=%b req=0", c, down_valid); end
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] req_hi;
`ifdef RIGHT_SHIFT_ARITH_EN
        req_hi = 8'hFF;
`else
        req_hi = 8'h01;
`endif
        down_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            up_valid = (c < 2);
            up_data  = (c == 0) ? 8'hA5 : 8'h80;
            up_shamt = (c == 0) ? 3'd0 : 3'd7;
            #1;
            if (c == 3) begin
                vecs++; if (down_valid !== 1'b1 || down_data !== 8'hA5) begin
                    errs++; $display("FAIL bound_shamt0 got=%b/%h req=1/a5", down_valid, down_data); end
            end
            if (c == 4) begin
                vecs++; if (down_valid !== 1'b1 || down_data !== req_hi) begin
                    errs++; $display("FAIL bound_shamt7 got=%b/%h req=1/%h", down_valid, down_data, req_hi); end
            end
        end
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last = -1;
        int popped = 0;
        logic [7:0] req;
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            down_ready = 1'b1;
            if (c < 16) begin
                up_valid = 1'b1; up_data = 8'(c + 1); up_shamt = 3'(c % 8);
            end else begin
                up_valid = 1'b0;
            end
            #1;
            if (down_valid && down_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL b2b_extra got=%h req=none", down_data);
                end else begin
                    req = exp_q.pop_front();
                    if (down_data !== req) begin errs++; $display("FAIL b2b_data n=%0d got=%h req=%h", popped, down_data, req); end
                end
                if (first < 0) first = c;
                last = c;
                popped++;
            end
            if (up_valid && up_ready) exp_q.push_back(model(up_data, up_shamt));
            if (c >= 16 && popped >= 16 && exp_q.size() == 0) break;
        end
        up_valid = 1'b0;
        vecs++; if (popped != 16) begin errs++; $display("FAIL b2b_count got=%0d req=16", popped); end
        vecs++; if (last - first != 15) begin errs++; $display("FAIL b2b_rate got=%0d req=15", last - first); end
    endtask

    task automatic test_stall();
        logic [7:0] dat [6] = '{8'h3C, 8'hC3, 8'h99, 8'h7E, 8'h42, 8'hE1};
        logic [2:0] sh  [6] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0};
        int wi = 0;
        int popped = 0;
        logic [7:0] req;
        exp_q.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            down_ready = !(c >= 3 && c < 8);
            up_valid = (wi < 6);
            if (wi < 6) begin up_data = dat[wi]; up_shamt = sh[wi]; end
            #1;
            if (!down_ready) begin
                vecs++; if (up_ready !== 1'b0) begin errs++; $display("FAIL stall_up_ready c=%0d got=%b req=0", c, up_ready); end
                vecs++; if (down_valid !== 1'b1 || exp_q.size() == 0 || down_data !== exp_q[0]) begin
                    errs++; $display("FAIL stall_hold c=%0d got=%b/%h req=1/%h", c, down_valid, down_data,
                                     (exp_q.size() != 0) ? exp_q[0] : 8'h00); end
            end
            if (down_valid && down_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++; $display("FAIL stall_extra got=%h req=none", down_data);
                end else begin
                    req = exp_q.pop_front();
                    if (down_data !== req) begin errs++; $display("FAIL stall_data n=%0d got=%h req=%h", popped, down_data, req); end
                end
                popped++;
            end
            if (up_valid && up_ready) begin
                exp_q.push_back(model(up_data, up_shamt));
                wi++;
            end
            if (wi == 6 && exp_q.size() == 0) break;
        end
        up_valid = 1'b0;
        down_ready = 1'b1;
        vecs++; if (popped != 6) begin errs++; $display("FAIL stall_count got=%0d req=6", popped); end
    endtask

    task automatic test_bubbles();
        logic       req_v [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] req_a, req_b;
`ifdef RIGHT_SHIFT_ARITH_EN
        req_a = 8'hFF;
`else
        req_a = 8'h0F;
`endif
        req_b = 8'h1B;
        down_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            up_valid = (c == 0) || (c == 2);
            up_data  = (c == 0) ? 8'hF0 : 8'h6C;
            up_shamt = (c == 0) ? 3'd4 : 3'd2;
            #1;
            if (c >= 1) begin
                vecs++; if (down_valid !== req_v[c]) begin errs++; $display("FAIL bubble_valid c=%0d got=%b req=%b", c, down_valid, req_v[c]); end
            end
            if (c == 3) begin
                vecs++; if (down_data !== req_a) begin errs++; $display("FAIL bubble_data0 got=%h req=%h", down_data, req_a); end
            end
            if (c == 5) begin
                vecs++; if (down_data !== req_b) begin errs++; $display("FAIL bubble_data1 got=%h req=%h", down_data, req_b); end
            end
        end
        up_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] req;
`ifdef RIGHT_SHIFT_ARITH_EN
        req = 8'hFF;
`else
        req = 8'h07;
`endif
        down_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            up_valid = 1'b1; up_data = 8'(8'h11 * (c + 1)); up_shamt = 3'(c + 1);
        end
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        vecs++; if (down_valid !== 1'b1) begin errs++; $display("FAIL rstmid_full got=%b req=1", down_valid); end
        rst = 1'b1;
        #1;
        vecs++; if (down_valid !== 1'b0) begin errs++; $display("FAIL rstmid_async_valid got=%b req=0", down_valid); end
        vecs++; if (down_data !== 8'h00) begin errs++; $display("FAIL rstmid_async_data got=%h req=00", down_data); end
        @(negedge clk);
        rst = 1'b0;
        up_valid = 1'b1; up_data = 8'hE7; up_shamt = 3'd5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            up_valid = 1'b0;
            #1;
            if (c == 3) begin
                vecs++; if (down_valid !== 1'b1 || down_data !== req) begin
                    errs++; $display("FAIL rstmid_new got=%b/%h req=1/%h", down_valid, down_data, req); end
            end else begin
                vecs++; if (down_valid !== 1'b0) begin errs++; $display("FAIL rstmid_stale c=%0d got=%b req=0", c, down_valid); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_stall();
        test_bubbles();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
